handshake_rr_arb_mux: RTL and testbench
=======================================

Name: handshake_rr_arb_mux

Overview:
- N-input round-robin arbiter fused with a registered output stage.
- Each cycle it picks one valid input, forwards that input's data and index, and consumes only the granted input.
- It is the self-scheduling counterpart to the select-driven handshake mux: it generates the selection internally and shares one downstream consumer fairly between requesters.
- Sits in front of shared function units and memory ports in the handshake fabric.

Parameters:
- NUM_INPUTS, 4, number of requesters; legal range 1 to 64, non-power-of-2 allowed.
- WIDTH, 32, data width of each input and of the output.
- IDX_WIDTH, localparam = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1, width of the index and pointer.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- in_valid  input  NUM_INPUTS  per-requester valid.
- in_ready  output  NUM_INPUTS  per-requester ready; one-hot or zero.
- in_data  input  NUM_INPUTS x WIDTH  per-requester data, packed array.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream ready.
- out_data  output  WIDTH  registered data of the granted input.
- out_idx  output  IDX_WIDTH  registered index of the granted input.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values:
  - out_valid = 0, out_data = 0, out_idx = 0.
  - Round-robin pointer ptr = 0.
  - in_ready = 0 while rst_n = 0.
- Pick (combinational):
  - grant g = first index i with in_valid[i] = 1, searching ptr, ptr+1, ..., NUM_INPUTS-1, 0, ..., ptr-1.
  - any_req = |in_valid.
- Load condition: load = any_req && (!out_valid || out_ready).
- in_ready[i] = load && (i == g). Non-granted inputs are never consumed.
  - in_ready may depend on in_valid.
  - in_valid must never depend on in_ready.
- On load:
  - out_data <= in_data[g]; out_idx <= g; out_valid <= 1.
  - ptr <= (g == NUM_INPUTS-1) ? 0 : g+1. Wrap is explicit; no modulo-2^k wrap for non-power-of-2 N.
- Drain without refill: if out_valid && out_ready && !any_req, then out_valid <= 0. Data and idx hold their last values.
- Stall: if out_valid && !out_ready, then out_valid, out_data and out_idx hold, ptr holds, and in_ready = 0.
- Latency and throughput:
  - 1 cycle from input handshake to out_valid.
  - Full throughput: one transfer per cycle under continuous out_ready.
- Fairness:
  - A continuously asserted requester is granted within NUM_INPUTS loads.
  - ptr advances only on load.
- Corner cases:
  - NUM_INPUTS = 1: g = 0 always, ptr stays 0; the block reduces to a single-entry pipeline register.
  - Simultaneous output handshake and new load in the same cycle: the register is replaced with no bubble.
  - Reset mid-transfer: a held output word is discarded; no input is consumed during reset.
  - The first cycle after release behaves as empty.
- No combinational path from out_ready to out_valid/out_data/out_idx.
  - Path out_ready -> in_ready exists by design (no skid buffer).

Optional Feature:
- Macro HANDSHAKE_RR_ARB_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt (32 bits), counting cycles with out_valid && !out_ready.
  - Saturates at 32'hFFFF_FFFF; reset to 0 by rst_n.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package handshake_pkg:
  - idx_width(n) constant function implementing the IDX_WIDTH rule.
  - Shared typedef for the round-robin pointer width.
- Sub-module handshake_rr_pick:
  - Purely combinational rotate-priority picker.
  - Inputs: req vector, ptr. Outputs: grant index, any.
  - Reused by other arbiters in the fabric.
- Top module holds the output register, ptr and the optional counter.

Test Plan:
- Single requester, N = 4, in_valid = 4'b0100, data 0xA5, out_ready = 1 -> next cycle out_valid = 1, out_data = 0xA5, out_idx = 2; ptr = 3.
- All 4 valid continuously with distinct data, out_ready = 1 -> out_idx sequence 0,1,2,3,0 on consecutive cycles; exactly one in_ready high per cycle.
- Backpressure: fill output from input 1, hold out_ready = 0 for 5 cycles with input 3 valid -> out_data/idx stable and in_ready = 0 throughout. With the macro defined, stall_cnt = 5. Release -> input 3 granted in the same cycle as the output handshake.
- Non-power-of-2 N = 3, ptr at 2, in_valid = 3'b101 -> grant 2, ptr wraps to 0; next grant 0.
- Drain: one transfer then in_valid = 0, out_ready = 1 -> out_valid falls after one cycle; out_data retains its last value.
- Async reset asserted mid-stall with out_valid = 1 -> out_valid, out_idx and ptr = 0 immediately; in_ready = 0; no input consumed until after release.

Source files
------------

// File: rtl/handshake_pkg.sv
// Shared definitions for the handshake fabric arbiters.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package handshake_pkg;

   // Index/pointer width rule: a single requester still gets a 1-bit index.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Wide enough to hold any round-robin pointer or rotated distance
   // for up to 64 requesters (values 0..127), so no arithmetic wraps early.
   typedef logic [6:0] rr_ptr_t;

endpackage

// File: rtl/handshake_rr_pick.sv
// Rotate-priority picker: first asserted req at or after ptr, wrapping at N-1.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is used.
//
// Ports:
//   req   - request vector, one bit per requester
//   ptr   - highest-priority index this cycle (must be < N)
//   grant - index of the winning requester (0 when nothing requests)
//   any   - at least one request is asserted
module handshake_rr_pick
   import handshake_pkg::*;
#(
   parameter int N     = 4,
   parameter int IDX_W = idx_width(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] grant,
   output logic             any
);

   // Each requester's distance from ptr going upward with explicit wrap;
   // the smallest distance among asserted requests wins. This avoids
   // modulo-2^k wrap so non-power-of-2 N rotates correctly.
   always_comb begin
      int      p;
      rr_ptr_t d;
      rr_ptr_t best_d;
      grant  = '0;
      best_d = '1;
      d      = '0;
      p      = int'(ptr);
      for (int i = 0; i < N; i++) begin
         d = (i >= p) ? rr_ptr_t'(i - p) : rr_ptr_t'(i + N - p);
         if (req[i] && (d < best_d)) begin
            best_d = d;
            grant  = IDX_W'(i);
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/handshake_rr_arb_mux.sv
// Round-robin N:1 arbiter with a registered output word (data + source index).
// Latency: 1 cycle from input handshake to out_valid; one transfer per cycle.
// Backpressure: out_ready low holds the output and drops every in_ready.
//
// Ports:
//   clk, rst_n            - clock, async active-low reset
//   in_valid/in_ready     - per-requester handshake; in_ready is one-hot or zero
//   in_data               - per-requester data, packed array
//   out_valid/out_ready   - registered downstream handshake
//   out_data, out_idx     - registered data and index of the granted requester
//   stall_cnt             - only with HANDSHAKE_RR_ARB_STALL_CNT_EN: saturating
//                           count of cycles with out_valid && !out_ready
module handshake_rr_arb_mux
   import handshake_pkg::*;
#(
   parameter  int NUM_INPUTS = 4,
   parameter  int WIDTH      = 32,
   localparam int IDX_WIDTH  = idx_width(NUM_INPUTS)
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_INPUTS-1:0]            in_valid,
   output logic [NUM_INPUTS-1:0]            in_ready,
   input  logic [NUM_INPUTS-1:0][WIDTH-1:0] in_data,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [WIDTH-1:0]                 out_data,
   output logic [IDX_WIDTH-1:0]             out_idx
`ifdef HANDSHAKE_RR_ARB_STALL_CNT_EN
   ,
   output logic [31:0]                      stall_cnt
`endif
);

   logic                 out_valid_q, out_valid_d;
   logic [WIDTH-1:0]     out_data_q,  out_data_d;
   logic [IDX_WIDTH-1:0] out_idx_q,   out_idx_d;
   logic [IDX_WIDTH-1:0] ptr_q,       ptr_d;

   logic [IDX_WIDTH-1:0] grant;
   logic                 any_req;
   logic                 load;

   handshake_rr_pick #(
      .N     (NUM_INPUTS),
      .IDX_W (IDX_WIDTH)
   ) u_pick (
      .req   (in_valid),
      .ptr   (ptr_q),
      .grant (grant),
      .any   (any_req)
   );

   // rst_n gates load so nothing is consumed while reset is held, even
   // though the registers are already empty then.
   assign load = rst_n && any_req && (!out_valid_q || out_ready);

   always_comb begin
      in_ready = '0;
      if (load) begin
         in_ready[grant] = 1'b1;
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_idx_d   = out_idx_q;
      ptr_d       = ptr_q;
      if (load) begin
         out_valid_d = 1'b1;
         out_data_d  = in_data[grant];
         out_idx_d   = grant;
         ptr_d       = (grant == IDX_WIDTH'(NUM_INPUTS - 1)) ? '0 : grant + IDX_WIDTH'(1);
      end else if (out_ready) begin
         // Drained with nothing to refill; data/idx keep their last values.
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
         ptr_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_idx_q   <= out_idx_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_idx   = out_idx_q;

`ifdef HANDSHAKE_RR_ARB_STALL_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (out_valid_q && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_handshake_rr_arb_mux.sv
// Directed bench for handshake_rr_arb_mux: a 4-input and a 3-input instance.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// Expected values are hand-derived constants.
module tb_handshake_rr_arb_mux;

   logic clk;
   logic rst_n;

   // 4-input instance
   logic [3:0]       in_valid;
   logic [3:0]       in_ready;
   logic [3:0][31:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_data;
   logic [1:0]       out_idx;

   // 3-input instance
   logic [2:0]       v3;
   logic [2:0]       r3;
   logic [2:0][31:0] d3;
   logic             ov3;
   logic             or3;
   logic [31:0]      od3;
   logic [1:0]       oi3;

`ifdef HANDSHAKE_RR_ARB_STALL_CNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] stall_cnt3;
`endif

   int checks = 0;
   int errors = 0;

   handshake_rr_arb_mux #(.NUM_INPUTS(4), .WIDTH(32)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx)
`ifdef HANDSHAKE_RR_ARB_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   handshake_rr_arb_mux #(.NUM_INPUTS(3), .WIDTH(32)) u_dut3 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (v3),
      .in_ready  (r3),
      .in_data   (d3),
      .out_valid (ov3),
      .out_ready (or3),
      .out_data  (od3),
      .out_idx   (oi3)
`ifdef HANDSHAKE_RR_ARB_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt3)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [1:0] seq [6];
      seq = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

      rst_n     = 1'b0;
      in_valid  = 4'hF;
      in_data   = '0;
      out_ready = 1'b1;
      v3        = '0;
      d3        = '0;
      or3       = 1'b1;
      #2;
      // Reset state, with requests already asserted
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data",  64'(out_data),  64'd0);
      check("rst_out_idx",   64'(out_idx),   64'd0);
      check("rst_in_ready",  64'(in_ready),  64'd0);
      tick();
      check("rst_hold_in_ready", 64'(in_ready), 64'd0);
      check("rst_hold_out_valid", 64'(out_valid), 64'd0);
      in_valid = 4'b0000;
      rst_n    = 1'b1;
      #1;

      // Single requester 2 with 0xA5
      in_valid   = 4'b0100;
      in_data[2] = 32'hA5;
      #1;
      check("single_in_ready", 64'(in_ready), 64'b0100);
      tick();
      check("single_out_valid", 64'(out_valid), 64'd1);
      check("single_out_data",  64'(out_data),  64'hA5);
      check("single_out_idx",   64'(out_idx),   64'd2);

      // All four requesting: ptr now 3, so order 3,0,1,2,3,0
      in_valid = 4'hF;
      for (int i = 0; i < 4; i++) in_data[i] = 32'h10 + 32'(i);
      for (int k = 0; k < 6; k++) begin
         #1;
         check($sformatf("rr_in_ready_%0d", k), 64'(in_ready), 64'(4'b0001 << seq[k]));
         tick();
         check($sformatf("rr_out_idx_%0d", k),  64'(out_idx),  64'(seq[k]));
         check($sformatf("rr_out_data_%0d", k), 64'(out_data), 64'h10 + 64'(seq[k]));
      end

      // Drain: no requests, output handshakes and empties, data retained
      in_valid = 4'b0000;
      #1;
      check("drain_in_ready", 64'(in_ready), 64'd0);
      tick();
      check("drain_out_valid", 64'(out_valid), 64'd0);
      check("drain_out_data",  64'(out_data),  64'h10);
      check("drain_out_idx",   64'(out_idx),   64'd0);

      // Backpressure: load from input 1 (ptr is 1)
      in_valid   = 4'b0010;
      in_data[1] = 32'hB1;
      #1;
      check("bp_fill_in_ready", 64'(in_ready), 64'b0010);
      tick();
      in_valid   = 4'b1000;
      in_data[3] = 32'hC3;
      out_ready  = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         check($sformatf("bp_in_ready_%0d", k), 64'(in_ready), 64'd0);
         tick();
         check($sformatf("bp_out_valid_%0d", k), 64'(out_valid), 64'd1);
         check($sformatf("bp_out_data_%0d", k),  64'(out_data),  64'hB1);
         check($sformatf("bp_out_idx_%0d", k),   64'(out_idx),   64'd1);
      end
`ifdef HANDSHAKE_RR_ARB_STALL_CNT_EN
      check("bp_stall_cnt", 64'(stall_cnt), 64'd5);
`endif
      // Release: input 3 granted in the same cycle as the output handshake
      out_ready = 1'b1;
      #1;
      check("bp_release_in_ready", 64'(in_ready), 64'b1000);
      tick();
      check("bp_release_out_valid", 64'(out_valid), 64'd1);
      check("bp_release_out_data",  64'(out_data),  64'hC3);
      check("bp_release_out_idx",   64'(out_idx),   64'd3);
`ifdef HANDSHAKE_RR_ARB_STALL_CNT_EN
      check("bp_release_stall_cnt", 64'(stall_cnt), 64'd5);
`endif

      // Load input 0 so ptr becomes 1, then stall with everyone requesting
      in_valid   = 4'b0001;
      in_data[0] = 32'hD0;
      #1;
      check("pre_rst_in_ready", 64'(in_ready), 64'b0001);
      tick();
      check("pre_rst_out_idx", 64'(out_idx), 64'd0);
      out_ready = 1'b0;
      in_valid  = 4'hF;
      tick();
      check("pre_rst_stall_valid", 64'(out_valid), 64'd1);
      // Asynchronous reset mid-cycle
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", 64'(out_valid), 64'd0);
      check("arst_out_idx",   64'(out_idx),   64'd0);
      check("arst_out_data",  64'(out_data),  64'd0);
      check("arst_in_ready",  64'(in_ready),  64'd0);
`ifdef HANDSHAKE_RR_ARB_STALL_CNT_EN
      check("arst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
      out_ready = 1'b1;
      tick();
      check("arst_hold_in_ready", 64'(in_ready), 64'd0);
      check("arst_hold_out_valid", 64'(out_valid), 64'd0);
      rst_n = 1'b1;
      #1;
      // ptr back at 0, so input 0 wins rather than input 1
      check("post_rst_in_ready", 64'(in_ready), 64'b0001);
      tick();
      check("post_rst_out_valid", 64'(out_valid), 64'd1);
      check("post_rst_out_idx",   64'(out_idx),   64'd0);
      in_valid = 4'b0000;

      // Non-power-of-2: N=3, move ptr to 2 then request 3'b101
      v3    = 3'b010;
      d3[1] = 32'h31;
      #1;
      check("n3_first_in_ready", 64'(r3), 64'b010);
      tick();
      check("n3_first_out_idx", 64'(oi3), 64'd1);
      v3    = 3'b101;
      d3[0] = 32'h30;
      d3[2] = 32'h32;
      #1;
      check("n3_grant2_in_ready", 64'(r3), 64'b100);
      tick();
      check("n3_grant2_out_idx",  64'(oi3), 64'd2);
      check("n3_grant2_out_data", 64'(od3), 64'h32);
      #1;
      check("n3_wrap_in_ready", 64'(r3), 64'b001);
      tick();
      check("n3_wrap_out_idx",   64'(oi3), 64'd0);
      check("n3_wrap_out_data",  64'(od3), 64'h30);
      check("n3_wrap_out_valid", 64'(ov3), 64'd1);
      v3 = 3'b000;
      tick();
      check("n3_drain_out_valid", 64'(ov3), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
